// File: rtl/video_buffer_filler.sv
// video_buffer_filler: fetches BSIZE bytes from frame memory, packs them LSB-first, and loads the word into the buffer when it reports empty
module video_buffer_filler #(
  parameter int BSIZE       = 4,
  parameter int ADDR_W      = 16,
  parameter int FRAME_BYTES = 19200
) (
  input  logic                 clk25MHz,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 buf_empty,
  input  logic                 buf_en,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd,
  input  logic [7:0]           mem_data,
  output logic [BSIZE*8-1:0]   data,
  output logic                 load,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 underrun
);
  localparam int W = BSIZE * 8;
  localparam int CW = BSIZE > 1 ? $clog2(BSIZE) : 1;
  localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(FRAME_BYTES);
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, HOLD, LOAD} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0] cnt;
  logic armed, start, wrap;
  // armed blocks a frame_start arriving on the same edge that reset is released
  assign start = frame_start & armed;
  assign wrap = addr == END_ADDR;
  assign mem_rd = state == FETCH;
  assign mem_addr = mem_rd ? addr : '0;
  assign load = state == LOAD && buf_empty && !start;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    if (start) state_nx = FETCH;
    else
      case (state)
        FETCH:   state_nx = cnt == CW'(BSIZE - 1) ? DRAIN : FETCH;
        DRAIN:   state_nx = HOLD;
        HOLD:    state_nx = buf_empty ? LOAD : HOLD;
        LOAD:    state_nx = !buf_empty ? HOLD : wrap ? IDLE : FETCH;
        default: state_nx = state;
      endcase
  end
  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      cnt        <= '0;
      data       <= '0;
      armed      <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nx;
      armed      <= 1'b1;
      frame_done <= load && wrap;
      cnt        <= (state == FETCH && !start) ? cnt + 1'b1 : '0;
      if (start || (load && wrap)) addr <= '0;
      else if (mem_rd) addr <= addr + 1'b1;
      // bytes shift in from the top so byte 0 ends in the LSB lane after BSIZE captures
      if ((state == FETCH && cnt != '0) || state == DRAIN)
        data <= (data >> 8) | (W'(mem_data) << (W - 8));
      if (start) underrun <= 1'b0;
      else if (buf_empty && buf_en && (state == FETCH || state == DRAIN)) underrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_video_buffer_filler.sv
// tb_video_buffer_filler: scoreboard bench; stimulus queues the words a frame should deliver, a monitor checks each load
module tb_video_buffer_filler;
  localparam int BSIZE = 4;
  localparam int ADDR_W = 16;
  localparam int FRAME_BYTES = 8;
  localparam int W = BSIZE * 8;
  localparam int WORDS = FRAME_BYTES / BSIZE;
  logic clk25MHz = 0, rst_n = 0, frame_start = 0, buf_empty = 0, buf_en = 0;
  logic mem_rd, load, busy, frame_done, underrun;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_data = 0;
  logic [W-1:0] data;
  int checks = 0, fails = 0;
  logic [W-1:0] exp_q[$];
  logic done_due = 0, load_prev = 0;
  video_buffer_filler #(.BSIZE(BSIZE), .ADDR_W(ADDR_W), .FRAME_BYTES(FRAME_BYTES)) dut (
    .clk25MHz(clk25MHz), .rst_n(rst_n), .frame_start(frame_start), .buf_empty(buf_empty),
    .buf_en(buf_en), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .data(data),
    .load(load), .busy(busy), .frame_done(frame_done), .underrun(underrun));
  always #20 clk25MHz = ~clk25MHz;
  always @(posedge clk25MHz) mem_data <= mem_addr[7:0];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [W-1:0] word(input int w);
    logic [W-1:0] r;
    for (int b = 0; b < BSIZE; b++) r[8*b +: 8] = 8'(w * BSIZE + b);
    return r;
  endfunction
  task automatic queue_frame();
    exp_q.delete();
    for (int w = 0; w < WORDS; w++) exp_q.push_back(word(w));
  endtask
  task automatic tick();
    @(posedge clk25MHz);
    #1;
  endtask
  task automatic start_frame();
    frame_start = 1;
    queue_frame();
    tick();
    frame_start = 0;
  endtask
  task automatic wait_until(input string name, input int what, input int a);
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      hit = what == 0 ? (mem_rd && mem_addr == ADDR_W'(a)) : what == 1 ? load : !busy;
    end
    if (!hit) check({name, "_timeout"}, 0, 1);
  endtask
  always @(negedge clk25MHz) begin
    if (!rst_n) begin
      done_due = 0;
      load_prev = 0;
    end else begin
      if (done_due) begin
        check("frame_done_pulse", frame_done, 1);
        done_due = 0;
      end else check("no_stray_frame_done", frame_done, 0);
      if (mem_rd) check("addr_in_frame", mem_addr < FRAME_BYTES, 1);
      if (load) begin
        check("load_needs_empty", buf_empty, 1);
        check("load_not_back_to_back", load_prev, 0);
        if (exp_q.size() == 0) check("unexpected_load", data, 0);
        else begin
          check("load_data", data, exp_q.pop_front());
          if (exp_q.size() == 0) done_due = 1;
        end
      end
      load_prev = load;
    end
  end
  initial begin
    repeat (3) @(posedge clk25MHz);
    #1;
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_data", data, 0);
    check("rst_load", load, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_underrun", underrun, 0);
    rst_n = 1;
    repeat (3) tick();
    check("idle_quiet", busy, 0);
    start_frame();
    for (int k = 0; k < BSIZE; k++) begin
      check("fetch_rd", mem_rd, 1);
      check("fetch_addr", mem_addr, k);
      tick();
    end
    check("drain_no_rd", mem_rd, 0);
    tick();
    check("hold_busy", busy, 1);
    check("hold_data", data, 32'h03020100);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_no_load", load, 0);
    end
    buf_empty = 1;
    tick();
    check("load_after_empty", load, 1);
    check("load_word0", data, 32'h03020100);
    tick();
    check("refetch_rd", mem_rd, 1);
    check("refetch_addr", mem_addr, 4);
    wait_until("frame_end", 2, 0);
    check("end_mem_addr", mem_addr, 0);
    check("end_busy", busy, 0);
    start_frame();
    wait_until("word1_fetch", 0, 6);
    frame_start = 1;
    queue_frame();
    tick();
    frame_start = 0;
    check("abort_addr", mem_addr, 0);
    check("abort_rd", mem_rd, 1);
    wait_until("abort_frame_end", 2, 0);
    buf_en = 1;
    start_frame();
    tick();
    check("underrun_set", underrun, 1);
    buf_en = 0;
    wait_until("underrun_load", 1, 0);
    check("underrun_held_load", underrun, 1);
    start_frame();
    check("underrun_cleared", underrun, 0);
    buf_en = 1;
    wait_until("word_end", 0, 3);
    buf_empty = 0;
    buf_en = 0;
    tick();
    tick();
    check("pre_rst_data", data, 32'h03020100);
    #5 rst_n = 0;
    #1;
    check("arst_load", load, 0);
    check("arst_busy", busy, 0);
    check("arst_data", data, 0);
    check("arst_underrun", underrun, 0);
    check("arst_mem_rd", mem_rd, 0);
    exp_q.delete();
    tick();
    rst_n = 1;
    buf_empty = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_idle", busy, 0);
    end
    for (int i = 0; i < 3000; i++) begin
      buf_empty = $urandom_range(2) != 0;
      buf_en = $urandom_range(1);
      if (!busy || $urandom_range(49) == 0) begin
        frame_start = 1;
        queue_frame();
      end else frame_start = 0;
      tick();
    end
    frame_start = 0;
    buf_empty = 1;
    wait_until("final_drain", 2, 0);
    tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
